hazard_ctrl_unit: RTL and testbench

- Pipeline control block that drives the enable and flush inputs of the F/D, D/E and E/M pipeline registers.
- Detects load-use hazards and resolves taken branches/jumps.
- Sequences the multi-cycle divider through a small FSM that freezes the front of the pipeline.
- Produces the execute-stage operand forwarding selects.

---
 rtl/hazard_ctrl_unit.sv | 120 ++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: load-use stall, redirect flush, divider sequencing, operand forwarding.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int DIV_LATENCY = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            D_ra,
  input  logic [4:0]            D_rb,
  input  logic [4:0]            E_ra,
  input  logic [4:0]            E_rb,
  input  logic [4:0]            E_rd,
  input  logic                  E_RegWrite,
  input  logic [1:0]            E_result_src,
  input  logic                  E_is_div,
  input  logic                  E_redirect,
  input  logic                  div_done,
  input  logic [4:0]            M_rd,
  input  logic                  M_RegWrite,
  input  logic [4:0]            W_rd,
  input  logic                  W_RegWrite,
  output logic                  F_en,
  output logic                  F_D_en,
  output logic                  F_D_flush,
  output logic                  D_E_en,
  output logic                  CTRL_Flush,
  output logic                  E_M_bubble,
  output logic                  div_start,
  output logic [1:0]            forwardA_E,
  output logic [1:0]            forwardB_E,
  output logic [DATA_WIDTH-1:0] stall_cycles,
  output logic [DATA_WIDTH-1:0] flush_events
);

  localparam int CW = $clog2(DIV_LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          div_launch;
  logic          div_stall, redirect, load_use;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_launch = 1'b0;
    case (state_q)
      IDLE: begin
        if (E_is_div) begin
          div_launch = 1'b1;
          cnt_d      = CW'(DIV_LATENCY - 1);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        // Completion and timeout landing together still make one transition.
        if (div_done || cnt_q == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign div_stall = !rst && ((state_q == IDLE && E_is_div) || state_q == BUSY);
  assign redirect  = !rst && !div_stall && E_redirect;
  assign load_use  = !rst && !div_stall && !E_redirect && E_RegWrite &&
                     (E_result_src == 2'b01) && (E_rd != 5'd0) &&
                     (E_rd == D_ra || E_rd == D_rb);

  assign F_en       = !(div_stall || load_use);
  assign F_D_en     = !(div_stall || load_use);
  assign D_E_en     = !div_stall;
  assign F_D_flush  = redirect;
  assign CTRL_Flush = redirect || load_use;
  assign E_M_bubble = div_stall;
  assign div_start  = !rst && div_launch;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (M_RegWrite && M_rd != 5'd0 && M_rd == src)      return 2'b10;
    else if (W_RegWrite && W_rd != 5'd0 && W_rd == src) return 2'b01;
    else                                               return 2'b00;
  endfunction

  assign forwardA_E = fwd_sel(E_ra);
  assign forwardB_E = fwd_sel(E_rb);

`ifdef HAZARD_PERF_CNT_EN
  logic [DATA_WIDTH-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!F_en && stall_q != '1)   stall_q <= stall_q + 1'b1;
      if (redirect && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit; a second instance with DIV_LATENCY=4 covers the timeout path.
module tb_hazard_ctrl_unit;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] D_ra, D_rb, E_ra, E_rb, E_rd, M_rd, W_rd;
  logic E_RegWrite, E_is_div, E_is_div4, E_redirect, div_done, M_RegWrite, W_RegWrite;
  logic [1:0] E_result_src;

  logic F_en, F_D_en, F_D_flush, D_E_en, CTRL_Flush, E_M_bubble, div_start;
  logic [1:0] forwardA_E, forwardB_E;
  logic [31:0] stall_cycles, flush_events;

  logic F_en4, F_D_en4, F_D_flush4, D_E_en4, CTRL_Flush4, E_M_bubble4, div_start4;
  logic [1:0] forwardA_E4, forwardB_E4;
  logic [31:0] stall_cycles4, flush_events4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.DATA_WIDTH(32), .DIV_LATENCY(33)) u_dut (
    .clk(clk), .rst(rst), .D_ra(D_ra), .D_rb(D_rb), .E_ra(E_ra), .E_rb(E_rb),
    .E_rd(E_rd), .E_RegWrite(E_RegWrite), .E_result_src(E_result_src),
    .E_is_div(E_is_div), .E_redirect(E_redirect), .div_done(div_done),
    .M_rd(M_rd), .M_RegWrite(M_RegWrite), .W_rd(W_rd), .W_RegWrite(W_RegWrite),
    .F_en(F_en), .F_D_en(F_D_en), .F_D_flush(F_D_flush), .D_E_en(D_E_en),
    .CTRL_Flush(CTRL_Flush), .E_M_bubble(E_M_bubble), .div_start(div_start),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  hazard_ctrl_unit #(.DATA_WIDTH(32), .DIV_LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .D_ra(D_ra), .D_rb(D_rb), .E_ra(E_ra), .E_rb(E_rb),
    .E_rd(E_rd), .E_RegWrite(E_RegWrite), .E_result_src(E_result_src),
    .E_is_div(E_is_div4), .E_redirect(E_redirect), .div_done(1'b0),
    .M_rd(M_rd), .M_RegWrite(M_RegWrite), .W_rd(W_rd), .W_RegWrite(W_RegWrite),
    .F_en(F_en4), .F_D_en(F_D_en4), .F_D_flush(F_D_flush4), .D_E_en(D_E_en4),
    .CTRL_Flush(CTRL_Flush4), .E_M_bubble(E_M_bubble4), .div_start(div_start4),
    .forwardA_E(forwardA_E4), .forwardB_E(forwardB_E4),
    .stall_cycles(stall_cycles4), .flush_events(flush_events4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow after #2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    D_ra = 0; D_rb = 0; E_ra = 0; E_rb = 0; E_rd = 0; M_rd = 0; W_rd = 0;
    E_RegWrite = 0; E_result_src = 2'b00; E_is_div = 0; E_is_div4 = 0;
    E_redirect = 0; div_done = 0; M_RegWrite = 0; W_RegWrite = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_fen"},    {31'd0, F_en},       32'd1);
    check({tag, "_fden"},   {31'd0, F_D_en},     32'd1);
    check({tag, "_deen"},   {31'd0, D_E_en},     32'd1);
    check({tag, "_fdfl"},   {31'd0, F_D_flush},  32'd0);
    check({tag, "_ctrl"},   {31'd0, CTRL_Flush}, 32'd0);
    check({tag, "_bub"},    {31'd0, E_M_bubble}, 32'd0);
    check({tag, "_dstart"}, {31'd0, div_start},  32'd0);
  endtask

  task automatic check_div_stall(input string tag, input logic exp_start);
    check({tag, "_fen"},    {31'd0, F_en},       32'd0);
    check({tag, "_fden"},   {31'd0, F_D_en},     32'd0);
    check({tag, "_deen"},   {31'd0, D_E_en},     32'd0);
    check({tag, "_bub"},    {31'd0, E_M_bubble}, 32'd1);
    check({tag, "_dstart"}, {31'd0, div_start},  {31'd0, exp_start});
  endtask

  logic [31:0] flush_before;

  initial begin
    quiet();
    rst = 1'b1;
    tick(); tick(); #2;
    check_idle("rst");
    check("rst_stall_cnt", stall_cycles, 32'd0);
    check("rst_flush_cnt", flush_events, 32'd0);
    tick(); rst = 1'b0; #2;
    check_idle("post_rst");

    // Load-use via D_ra, then via D_rb, then suppressed cases.
    E_RegWrite = 1; E_result_src = 2'b01; E_rd = 5; D_ra = 5; #2;
    check("lu_fen",  {31'd0, F_en},       32'd0);
    check("lu_fden", {31'd0, F_D_en},     32'd0);
    check("lu_ctrl", {31'd0, CTRL_Flush}, 32'd1);
    check("lu_deen", {31'd0, D_E_en},     32'd1);
    check("lu_fdfl", {31'd0, F_D_flush},  32'd0);
    D_ra = 0; D_rb = 5; #2;
    check("lu_rb_fen", {31'd0, F_en}, 32'd0);
    E_rd = 0; D_rb = 0; #2;
    check("lu_x0_fen",  {31'd0, F_en},       32'd1);
    check("lu_x0_ctrl", {31'd0, CTRL_Flush}, 32'd0);
    E_rd = 5; D_ra = 5; E_result_src = 2'b00; #2;
    check("lu_alu_fen", {31'd0, F_en}, 32'd1);
    E_result_src = 2'b01;

    // Redirect on top of a load-use hazard: flush wins, no stall.
    tick();
    flush_before = flush_events;
    E_redirect = 1; #2;
    check("rd_fdfl", {31'd0, F_D_flush},  32'd1);
    check("rd_ctrl", {31'd0, CTRL_Flush}, 32'd1);
    check("rd_fen",  {31'd0, F_en},       32'd1);
    check("rd_fden", {31'd0, F_D_en},     32'd1);
    tick(); quiet(); #2;
`ifdef HAZARD_PERF_CNT_EN
    check("rd_flush_cnt", flush_events, flush_before + 32'd1);
`else
    check("rd_flush_cnt", flush_events, 32'd0);
    check("rd_stall_cnt", stall_cycles, 32'd0);
`endif

    // Forwarding priority and x0 exclusion.
    E_ra = 7; M_rd = 7; W_rd = 7; M_RegWrite = 1; W_RegWrite = 1; #2;
    check("fwdA_m", {30'd0, forwardA_E}, 32'd2);
    M_RegWrite = 0; #2;
    check("fwdA_w", {30'd0, forwardA_E}, 32'd1);
    E_rb = 7; M_RegWrite = 1; W_rd = 3; #2;
    check("fwdB_m", {30'd0, forwardB_E}, 32'd2);
    E_ra = 0; E_rb = 0; M_rd = 0; W_rd = 0; #2;
    check("fwdB_x0", {30'd0, forwardB_E}, 32'd0);
    check("fwdA_x0", {30'd0, forwardA_E}, 32'd0);
    quiet();

    // Divide completed by div_done on the 5th BUSY cycle.
    tick(); E_is_div = 1; #2;
    check_div_stall("div_launch", 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 5) div_done = 1;
      #2;
      check_div_stall($sformatf("div_busy%0d", i), 1'b0);
    end
    tick(); div_done = 0; #2;
    check_idle("div_done");
    tick(); E_is_div = 0; #2;
    check_idle("div_idle");

    // Timeout on the DIV_LATENCY=4 instance: launch + 4 BUSY, then DONE.
    tick(); E_is_div4 = 1; #2;
    check("to_launch_start", {31'd0, div_start4}, 32'd1);
    check("to_launch_fen",   {31'd0, F_en4},      32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick(); #2;
      check($sformatf("to_busy%0d_fen", i),   {31'd0, F_en4},       32'd0);
      check($sformatf("to_busy%0d_bub", i),   {31'd0, E_M_bubble4}, 32'd1);
      check($sformatf("to_busy%0d_start", i), {31'd0, div_start4},  32'd0);
    end
    tick(); #2;
    check("to_done_fen",  {31'd0, F_en4},       32'd1);
    check("to_done_deen", {31'd0, D_E_en4},     32'd1);
    check("to_done_bub",  {31'd0, E_M_bubble4}, 32'd0);
    tick(); E_is_div4 = 0; #2;
    check("to_idle_fen", {31'd0, F_en4}, 32'd1);
    check("main_unaffected_fen", {31'd0, F_en}, 32'd1);

    // Reset during BUSY aborts the divide.
    tick(); E_is_div = 1; #2;
    check_div_stall("ab_launch", 1'b1);
    tick(); #2;
    check_div_stall("ab_busy", 1'b0);
    rst = 1; #2;
    check_idle("ab_rst");
    tick(); rst = 0; E_is_div = 0; #2;
    check_idle("ab_after");
    check("ab_stall_cnt", stall_cycles, 32'd0);
    check("ab_flush_cnt", flush_events, 32'd0);
    E_is_div = 1; #2;
    check("ab_fresh_start", {31'd0, div_start}, 32'd1);
    rst = 1; tick(); quiet(); rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
